// File: rtl/spike_sample_recorder.sv
// -----------------------------------------------------------------------------
// spike_sample_recorder
//
// Records a burst of spike-sample vectors into an on-chip buffer and plays
// them back on request.
//
//   IDLE    : waits for i_start.
//   CAPTURE : every i_valid cycle stores i_data. Capture ends after
//             MAX_SAMPLES stores or on i_stop.
//   DONE    : read-back. Each accepted i_rd_en returns one stored word one
//             cycle later. After the last word has been read the block
//             returns to IDLE. Samples offered in DONE are dropped and flagged.
//
// Parameters
//   DATA_W      : spike-sample vector width
//   ADDR_W      : buffer address width (depth = 2**ADDR_W)
//   MAX_SAMPLES : auto-stop sample count, 1 .. 2**ADDR_W
//
// Ports
//   i_clk         : clock, rising edge
//   i_rst         : synchronous active-high reset
//   i_start       : pulse, begins a new capture (ignored while capturing)
//   i_stop        : pulse, ends a capture early
//   i_valid       : i_data carries a sample this cycle
//   i_data        : spike-sample vector
//   o_ready       : high while capturing
//   i_rd_en       : read-request strobe (honoured in DONE)
//   o_rd_data     : read-back sample, holds its value between reads
//   o_rd_valid    : one-cycle pulse per accepted read
//   o_count       : samples stored in the current record
//   o_done        : high while in DONE
//   o_overflow    : sticky, a sample was offered in DONE
//   o_spike_total : (SPIKE_RECORDER_TOTAL_EN only) saturating 24-bit sum of
//                   popcount(i_data) over all stored samples
//
// Optional feature
//   Define SPIKE_RECORDER_TOTAL_EN to add o_spike_total and its popcount
//   accumulator. Without it the port and logic are absent.
// -----------------------------------------------------------------------------
module spike_sample_recorder #(
    parameter int DATA_W      = 42,
    parameter int ADDR_W      = 10,
    parameter int MAX_SAMPLES = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [ADDR_W:0]   o_count,
    output logic              o_done,
    output logic              o_overflow
`ifdef SPIKE_RECORDER_TOTAL_EN
    ,
    output logic [23:0]       o_spike_total
`endif
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_SAMPLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;    // one bit wider so it can equal o_count
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic              w_start_ok;  // i_start honoured (IDLE or DONE)
    logic              w_wr_en;     // store i_data this cycle
    logic              w_rd_accept; // read rd_ptr this cycle
    logic              w_ovf_set;   // sample offered while in DONE
    logic [ADDR_W:0]   w_count_inc;
    logic [ADDR_W:0]   w_rd_ptr_inc;

    assign w_count_inc  = r_count + 1'b1;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control strobes
    // -------------------------------------------------------------------------
    // NOTE: every signal written here receives a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_accept = 1'b0;
        w_ovf_set   = 1'b0;
        o_ready     = (r_state == ST_CAPTURE);
        o_done      = (r_state == ST_DONE);

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                // i_start is deliberately ignored here.
                w_wr_en = i_valid;
                // A sample arriving with i_stop is still stored.
                if ((i_valid && (w_count_inc == MAX_CNT)) || i_stop) begin
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                if (i_start) begin
                    // Restart wins; a same-cycle read request is discarded.
                    w_start_ok  = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_ovf_set = i_valid;
                    if (i_rd_en) begin
                        if (r_rd_ptr < r_count) begin
                            w_rd_accept = 1'b1;
                            // Leave once the final stored word is requested;
                            // its o_rd_valid still fires on the next cycle.
                            if (w_rd_ptr_inc == r_count) begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            // Only reachable with an empty record.
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Reset overrides every input, including the buffer write.
        if (i_rst) begin
            w_state_nxt = ST_IDLE;
            w_start_ok  = 1'b0;
            w_wr_en     = 1'b0;
            w_rd_accept = 1'b0;
            w_ovf_set   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, count and flags
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_start_ok) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_count  <= w_count_inc;
                end
                if (w_rd_accept) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
                if (w_ovf_set) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sample buffer: one write port, one registered read port
    // -------------------------------------------------------------------------
    // NOTE: the storage array carries no reset so it maps onto block RAM;
    // only the count bounds which words are ever read back.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Read register only loads on an accepted read, so the last word holds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (w_rd_accept) begin
            r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

`ifdef SPIKE_RECORDER_TOTAL_EN
    // -------------------------------------------------------------------------
    // Running popcount total over stored samples, saturating at all-ones
    // -------------------------------------------------------------------------
    localparam int PC_W = $clog2(DATA_W + 1);

    function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [PC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            acc = acc + PC_W'(v[i]);
        end
        return acc;
    endfunction

    logic [23:0] r_spike_total;
    logic [24:0] w_total_sum;   // extra bit catches the carry out

    assign w_total_sum = {1'b0, r_spike_total} + 25'(popcount(i_data));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_spike_total <= '0;
        end else if (w_start_ok) begin
            r_spike_total <= '0;
        end else if (w_wr_en) begin
            r_spike_total <= w_total_sum[24] ? 24'hFF_FFFF : w_total_sum[23:0];
        end
    end

    assign o_spike_total = r_spike_total;
`endif

endmodule

// File: doc/spike_sample_recorder.md
SPIKE_SAMPLE_RECORDER -- requirements
Module: spike_sample_recorder

Interface
REQ-001 SHALL have parameter DATA_W, default 42, meaning spike-sample vector width.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning buffer address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter MAX_SAMPLES, default 1000, meaning auto-stop sample count, 1..2**ADDR_W.
REQ-004 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_start  in  1  single-cycle pulse; begins a new capture.
REQ-007 SHALL have port i_stop  in  1  single-cycle pulse; ends capture early.
REQ-008 SHALL have port i_valid  in  1  i_data carries a sample this cycle.
REQ-009 SHALL have port i_data  in  DATA_W  spike sample vector.
REQ-010 SHALL have port o_ready  out  1  high only in CAPTURE.
REQ-011 SHALL have port i_rd_en  in  1  read-request strobe.
REQ-012 SHALL have port o_rd_data  out  DATA_W  read-back sample.
REQ-013 SHALL have port o_rd_valid  out  1  o_rd_data valid this cycle.
REQ-014 SHALL have port o_count  out  ADDR_W+1  samples stored in the current record.
REQ-015 SHALL have port o_done  out  1  high in DONE.
REQ-016 SHALL have port o_overflow  out  1  sticky: sample offered while not accepting after capture.

Function
REQ-017 SHALL implement states IDLE, CAPTURE, DONE.
REQ-018 IDLE: i_start -> CAPTURE next cycle, clearing wr_ptr, rd_ptr, o_count, o_overflow; i_valid ignored, no overflow.
REQ-019 CAPTURE: each cycle with i_valid=1 SHALL write i_data at wr_ptr and increment wr_ptr and o_count (o_count updates the cycle after the write).
REQ-020 CAPTURE -> DONE when the write makes o_count equal MAX_SAMPLES, or on i_stop; i_valid with i_stop in the same cycle SHALL store that sample, then go to DONE.
REQ-021 i_start during CAPTURE SHALL be ignored.
REQ-022 DONE: i_valid=1 SHALL drop the sample and set o_overflow; o_count unchanged.
REQ-023 DONE: i_rd_en with rd_ptr<o_count SHALL read address rd_ptr, increment rd_ptr; o_rd_data/o_rd_valid exactly 1 cycle later; o_rd_valid is a one-cycle pulse per accepted read.
REQ-024 DONE: i_rd_en with rd_ptr==o_count SHALL be ignored (no o_rd_valid).
REQ-025 DONE -> IDLE the cycle after the read of address o_count-1 is accepted; that word's o_rd_valid still SHALL assert; o_count and o_overflow hold until next i_start.
REQ-026 DONE with o_count=0 (i_stop before any sample) SHALL go to IDLE on the next i_rd_en, no o_rd_valid.
REQ-027 DONE: i_start SHALL restart capture (as REQ-018), taking priority over same-cycle i_rd_en, which is discarded.
REQ-028 o_rd_data SHALL hold its last value when o_rd_valid=0.
REQ-029 Buffer SHALL be a single inferred synchronous RAM, one write and one read port; no wrap-around (MAX_SAMPLES bound).

Reset
REQ-030 i_rst=1 SHALL force IDLE, wr_ptr=rd_ptr=0, o_count=0, o_ready=0, o_done=0, o_overflow=0, o_rd_valid=0, o_rd_data=0; RAM contents undefined.
REQ-031 Reset mid-capture or mid-read SHALL abort and take priority over all other inputs that cycle.

Configuration
REQ-032 Macro SPIKE_RECORDER_TOTAL_EN defined SHALL add port o_spike_total out 24: sum of popcount(i_data) over stored samples, cleared by reset and i_start, saturating at 24'hFFFFFF.
REQ-033 Without SPIKE_RECORDER_TOTAL_EN the port and popcount logic SHALL be absent; other behaviour identical.

Verification
REQ-034 Reset, i_start, 5 samples 42'h1, 42'h3, 42'h7, 42'hF, 42'h1F, i_stop -> o_done=1, o_count=5; 5 reads return same values in order, each 1 cycle after i_rd_en; IDLE after 5th.
REQ-035 MAX_SAMPLES=4, i_valid held 6 cycles -> o_count=4, DONE after 4th write, o_overflow=1 from the 5th offered sample.
REQ-036 i_valid with i_stop same cycle as 3rd sample -> o_count=3, third read returns that sample.
REQ-037 i_stop immediately after i_start -> o_count=0; i_rd_en -> no o_rd_valid, IDLE next cycle.
REQ-038 Reset pulse mid-capture after 2 samples -> all outputs at reset values next cycle; new i_start begins with o_count=0.
REQ-039 SPIKE_RECORDER_TOTAL_EN: samples 42'h3, 42'hFF, 42'h3FFFFFFFFFF -> o_spike_total=2+8+42=52.
